// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the sequential carry-save multiplier family.
`ifndef MULT_PKG_SV
`define MULT_PKG_SV

// Rejects accumulator widths that cannot hold a full product.
`define MULT_CHECK_ACC_W(acc_w, p_w) if ((acc_w) < (p_w)) begin : g_acc_w_too_small $error("ACC_W must be at least A_W+B_W"); end

package mult_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`endif

// File: rtl/mult_seq_cs_csa3to2.sv
// W-bit 3:2 compressor; the carry word comes out already aligned (shifted left by one).
module csa3to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] z_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] carry_o
);

  assign sum_o   = x_i ^ y_i ^ z_i;
  // The majority of the top column would land at bit W and is dropped.
  assign carry_o = {(x_i[W-2:0] & y_i[W-2:0]) |
                    (x_i[W-2:0] & z_i[W-2:0]) |
                    (y_i[W-2:0] & z_i[W-2:0]), 1'b0};

endmodule

// File: rtl/mult_seq_cs.sv
// Sequential unsigned multiply-accumulate: one multiplier bit per cycle into a
// carry-save pair, resolved to binary and accumulated in a final cycle.
module mult_seq_cs
  import mult_pkg::*;
#(
  parameter int A_W   = 5,
  parameter int B_W   = 3,
  parameter int ACC_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_W-1:0]       in_a,
  input  logic [B_W-1:0]       in_b,
  input  logic                 in_acc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     out_res,
  output logic [A_W+B_W-1:0]   out_sum,
  output logic [A_W+B_W-1:0]   out_carry
);

  localparam int P_W   = A_W + B_W;
  localparam int IDX_W = idx_width(B_W + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(B_W - 1);

  `MULT_CHECK_ACC_W(ACC_W, P_W)

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [P_W-1:0]     a_sh_q, a_sh_d;
  logic [B_W-1:0]     b_sh_q, b_sh_d;
  logic               acc_en_q, acc_en_d;
  logic [P_W-1:0]     sum_q, sum_d;
  logic [P_W-1:0]     carry_q, carry_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [P_W-1:0]     out_sum_q, out_sum_d;
  logic [P_W-1:0]     out_carry_q, out_carry_d;

  logic [P_W-1:0]     pp;
  logic [P_W-1:0]     csa_sum;
  logic [P_W-1:0]     csa_carry;
  logic [P_W-1:0]     prod;
  logic               accept;

  assign accept = in_valid & in_ready;

  // a_sh_q is pre-shifted to the current bit and b_sh_q exposes that bit at
  // position 0, so the partial product needs no variable shifter.
  assign pp   = b_sh_q[0] ? a_sh_q : '0;
  assign prod = sum_q + carry_q;

  csa3to2 #(
    .W (P_W)
  ) u_csa (
    .x_i     (sum_q),
    .y_i     (carry_q),
    .z_i     (pp),
    .sum_o   (csa_sum),
    .carry_o (csa_carry)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path through
  // the case leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = RESOLVE;
      RESOLVE: state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are pure decodes of the state register.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    idx_d       = idx_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    acc_en_d    = acc_en_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    acc_d       = acc_q;
    out_sum_d   = out_sum_q;
    out_carry_d = out_carry_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d    = '0;
          a_sh_d   = P_W'(in_a);
          b_sh_d   = in_b;
          acc_en_d = in_acc;
          sum_d    = '0;
          carry_d  = '0;
        end
      end
      RUN: begin
        sum_d   = csa_sum;
        carry_d = csa_carry;
        a_sh_d  = a_sh_q << 1;
        b_sh_d  = b_sh_q >> 1;
        idx_d   = idx_q + IDX_W'(1);
      end
      RESOLVE: begin
        acc_d       = (acc_en_q ? acc_q : '0) + ACC_W'(prod);
        out_sum_d   = sum_q;
        out_carry_d = carry_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      acc_en_q    <= 1'b0;
      sum_q       <= '0;
      carry_q     <= '0;
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_carry_q <= '0;
    end else begin
      idx_q       <= idx_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      acc_en_q    <= acc_en_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      acc_q       <= acc_d;
      out_sum_q   <= out_sum_d;
      out_carry_q <= out_carry_d;
    end
  end

  // The accumulator doubles as the result register.
  assign out_res   = acc_q;
  assign out_sum   = out_sum_q;
  assign out_carry = out_carry_q;

endmodule

// File: tb/tb_mult_seq_cs.sv
// Scoreboard bench for mult_seq_cs: default 5x3/8 instance plus an 8x4/16 instance.
module tb_mult_seq_cs;

  localparam int NA_W = 5, NB_W = 3, NACC_W = 8,  NP_W = 8;
  localparam int WA_W = 8, WB_W = 4, WACC_W = 16, WP_W = 12;

  typedef struct {
    int unsigned res;
    int unsigned prod;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int unsigned cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic              n_in_valid, n_in_ready, n_in_acc, n_out_valid, n_out_ready;
  logic [NA_W-1:0]   n_in_a;
  logic [NB_W-1:0]   n_in_b;
  logic [NACC_W-1:0] n_out_res;
  logic [NP_W-1:0]   n_out_sum, n_out_carry;

  logic              w_in_valid, w_in_ready, w_in_acc, w_out_valid, w_out_ready;
  logic [WA_W-1:0]   w_in_a;
  logic [WB_W-1:0]   w_in_b;
  logic [WACC_W-1:0] w_out_res;
  logic [WP_W-1:0]   w_out_sum, w_out_carry;

  mult_seq_cs #(.A_W(NA_W), .B_W(NB_W), .ACC_W(NACC_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (n_in_valid),
    .in_ready  (n_in_ready),
    .in_a      (n_in_a),
    .in_b      (n_in_b),
    .in_acc    (n_in_acc),
    .out_valid (n_out_valid),
    .out_ready (n_out_ready),
    .out_res   (n_out_res),
    .out_sum   (n_out_sum),
    .out_carry (n_out_carry)
  );

  mult_seq_cs #(.A_W(WA_W), .B_W(WB_W), .ACC_W(WACC_W)) u_wide (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_in_valid),
    .in_ready  (w_in_ready),
    .in_a      (w_in_a),
    .in_b      (w_in_b),
    .in_acc    (w_in_acc),
    .out_valid (w_out_valid),
    .out_ready (w_out_ready),
    .out_res   (w_out_res),
    .out_sum   (w_out_sum),
    .out_carry (w_out_carry)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  exp_t sb_n[$];
  exp_t sb_w[$];
  exp_t e_n, e_w;
  bit   n_seen = 1'b0;
  bit   w_seen = 1'b0;

  // Monitors: latency on first sight of out_valid, data on the handshake.
  always @(negedge clk) begin
    if (rst) begin
      n_seen = 1'b0;
    end else begin
      if (n_out_valid && !n_seen) begin
        n_seen = 1'b1;
        check("n_sb_depth", sb_n.size(), 1);
        if (sb_n.size() > 0) check("n_latency", cyc - sb_n[0].cyc, NB_W + 1);
      end
      if (n_out_valid && n_out_ready && sb_n.size() > 0) begin
        e_n = sb_n.pop_front();
        check("n_res", n_out_res, e_n.res);
        check("n_csa_pair", NP_W'(n_out_sum + n_out_carry), e_n.prod);
        n_seen = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      w_seen = 1'b0;
    end else begin
      if (w_out_valid && !w_seen) begin
        w_seen = 1'b1;
        check("w_sb_depth", sb_w.size(), 1);
        if (sb_w.size() > 0) check("w_latency", cyc - sb_w[0].cyc, WB_W + 1);
      end
      if (w_out_valid && w_out_ready && sb_w.size() > 0) begin
        e_w = sb_w.pop_front();
        check("w_res", w_out_res, e_w.res);
        check("w_csa_pair", WP_W'(w_out_sum + w_out_carry), e_w.prod);
        w_seen = 1'b0;
      end
    end
  end

  task automatic wait_ready_n();
    for (int i = 0; i < 50 && !n_in_ready; i++) begin
      @(posedge clk); #1;
    end
    check("n_ready_wait", n_in_ready, 1);
  endtask

  task automatic wait_ready_w();
    for (int i = 0; i < 50 && !w_in_ready; i++) begin
      @(posedge clk); #1;
    end
    check("w_ready_wait", w_in_ready, 1);
  endtask

  // Operands are scrambled right after the accept edge to show they were latched.
  task automatic issue_n(input logic [NA_W-1:0] a, input logic [NB_W-1:0] b, input logic acc,
                         input int unsigned res, input int unsigned prod);
    exp_t e;
    wait_ready_n();
    n_in_a = a; n_in_b = b; n_in_acc = acc; n_in_valid = 1'b1;
    @(posedge clk); #1;
    e.res = res; e.prod = prod; e.cyc = cyc;
    sb_n.push_back(e);
    n_in_valid = 1'b0; n_in_a = ~a; n_in_b = ~b; n_in_acc = ~acc;
  endtask

  task automatic issue_w(input logic [WA_W-1:0] a, input logic [WB_W-1:0] b, input logic acc,
                         input int unsigned res, input int unsigned prod);
    exp_t e;
    wait_ready_w();
    w_in_a = a; w_in_b = b; w_in_acc = acc; w_in_valid = 1'b1;
    @(posedge clk); #1;
    e.res = res; e.prod = prod; e.cyc = cyc;
    sb_w.push_back(e);
    w_in_valid = 1'b0; w_in_a = ~a; w_in_b = ~b; w_in_acc = ~acc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    n_in_valid = 1'b0; n_in_a = '0; n_in_b = '0; n_in_acc = 1'b0; n_out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_acc = 1'b0; w_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready",  n_in_ready, 1);
    check("rst_out_valid", n_out_valid, 0);
    check("rst_out_res",   n_out_res, 0);
    check("rst_out_sum",   n_out_sum, 0);
    check("rst_out_carry", n_out_carry, 0);

    // Basic product, wrap of the 8-bit accumulator, accumulate, zero operands.
    issue_n(5'd17, 3'd3, 1'b0, 51, 51);
    issue_n(5'd31, 3'd7, 1'b0, 217, 217);
    issue_n(5'd31, 3'd7, 1'b1, 178, 217);
    issue_n(5'd17, 3'd3, 1'b0, 51, 51);
    issue_n(5'd5,  3'd2, 1'b1, 61, 10);
    issue_n(5'd0,  3'd0, 1'b0, 0, 0);

    // Backpressure: result held, in_ready low, new requests ignored.
    wait_ready_n();
    n_out_ready = 1'b0;
    issue_n(5'd6, 3'd5, 1'b1, 30, 30);
    for (int i = 0; i < 20 && !n_out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("bp_valid_seen", n_out_valid, 1);
    for (int j = 0; j < 5; j++) begin
      n_in_valid = 1'b1; n_in_a = 5'd1; n_in_b = 3'd1; n_in_acc = 1'b1;
      @(posedge clk); #1;
      check("bp_hold_valid", n_out_valid, 1);
      check("bp_in_ready",   n_in_ready, 0);
      check("bp_hold_res",   n_out_res, 30);
      check("bp_hold_pair",  NP_W'(n_out_sum + n_out_carry), 30);
    end
    n_in_valid = 1'b0;
    n_out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", n_in_ready, 1);
    check("bp_release_valid", n_out_valid, 0);

    // Reset during the second RUN cycle discards the operation and the accumulator.
    wait_ready_n();
    n_in_a = 5'd7; n_in_b = 3'd7; n_in_acc = 1'b1; n_in_valid = 1'b1;
    @(posedge clk); #1;
    n_in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    sb_n.delete();
    #1;
    check("mid_rst_valid", n_out_valid, 0);
    check("mid_rst_res",   n_out_res, 0);
    check("mid_rst_sum",   n_out_sum, 0);
    check("mid_rst_carry", n_out_carry, 0);
    check("mid_rst_ready", n_in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    issue_n(5'd3, 3'd5, 1'b1, 15, 15);

    // Wider configuration.
    issue_w(8'd255, 4'd15, 1'b0, 3825, 3825);
    issue_w(8'd255, 4'd15, 1'b1, 7650, 3825);
    issue_w(8'd200, 4'd9,  1'b1, 9450, 1800);
    issue_w(8'd0,   4'd0,  1'b1, 9450, 0);
    issue_w(8'd128, 4'd10, 1'b0, 1280, 1280);
    issue_w(8'd1,   4'd1,  1'b1, 1281, 1);

    for (int i = 0; i < 100 && (sb_n.size() + sb_w.size()) != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check("drain", sb_n.size() + sb_w.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
